// File: rtl/sd_host_regfile.sv
// rtl/sd_host_regfile.sv - address-mapped SD host register bank
// Host req/ack access with byte enables, per-bit hw updates, RO/W1C/self-clear bits and masked irq.
module sd_host_regfile #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter logic [NUM_WORDS*DATA_W-1:0] RESET_VAL    = '0,
  parameter logic [NUM_WORDS*DATA_W-1:0] RO_MASK      =
    {{(NUM_WORDS*DATA_W-DATA_W){1'b0}}, {DATA_W{1'b1}}} << (9*DATA_W),
  parameter logic [NUM_WORDS*DATA_W-1:0] W1C_MASK     =
    {{(NUM_WORDS*DATA_W-16){1'b0}}, 16'hFFFF} << (12*DATA_W),
  parameter logic [NUM_WORDS*DATA_W-1:0] SELFCLR_MASK =
    {{(NUM_WORDS*DATA_W-1){1'b0}}, 1'b1} << (3*DATA_W+15),
  parameter int IRQ_STAT_IDX = 12,
  parameter int IRQ_EN_IDX   = 13
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             addrs,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W/8-1:0]           wr_be,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          host_ack,
  output logic                          host_err,
  input  logic [NUM_WORDS*DATA_W-1:0]   hw_wr_data,
  input  logic [NUM_WORDS*DATA_W-1:0]   hw_wr_en,
  output logic [NUM_WORDS*DATA_W-1:0]   reg_q,
  output logic [NUM_WORDS-1:0]          host_wr_strobe,
  output logic                          irq
);

  logic [NUM_WORDS*DATA_W-1:0] r_q;
  logic [NUM_WORDS*DATA_W-1:0] r_sc_pend;
  logic [DATA_W-1:0]           r_rd;
  logic                        r_ack;
  logic                        r_err;
  logic [NUM_WORDS-1:0]        r_strobe;
  logic                        r_irq;

  logic [ADDR_W-3:0]           w_idx;
  logic                        w_valid;
  logic [NUM_WORDS-1:0]        w_wsel;
  logic [NUM_WORDS-1:0]        w_strobe;
  logic [NUM_WORDS*DATA_W-1:0] w_nxt;
  logic [NUM_WORDS*DATA_W-1:0] w_sc_nxt;
  logic                        w_unused;

  assign w_idx    = addrs[ADDR_W-1:2];
  assign w_valid  = (32'(w_idx) < NUM_WORDS);
  assign w_unused = &{1'b0, addrs[1:0]};

  always_comb begin
    w_wsel   = '0;
    w_strobe = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      w_wsel[w]   = host_req & host_we & w_valid & (32'(w_idx) == w);
      w_strobe[w] = w_wsel[w] & (|wr_be);
    end
  end

  // Priority per bit: RO ignores the host; W1C lets a hw set beat a host clear;
  // RW/self-clear let the host beat hw, and a pending auto-clear is weakest.
  always_comb begin
    w_nxt    = r_q;
    w_sc_nxt = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (RO_MASK[w*DATA_W+b]) begin
          if (hw_wr_en[w*DATA_W+b]) w_nxt[w*DATA_W+b] = hw_wr_data[w*DATA_W+b];
        end else if (W1C_MASK[w*DATA_W+b]) begin
          if (hw_wr_en[w*DATA_W+b] && hw_wr_data[w*DATA_W+b])
            w_nxt[w*DATA_W+b] = 1'b1;
          else if (w_wsel[w] && wr_be[b/8] && wr_data[b])
            w_nxt[w*DATA_W+b] = 1'b0;
          else if (hw_wr_en[w*DATA_W+b])
            w_nxt[w*DATA_W+b] = hw_wr_data[w*DATA_W+b];
        end else begin
          if (w_wsel[w] && wr_be[b/8])
            w_nxt[w*DATA_W+b] = wr_data[b];
          else if (hw_wr_en[w*DATA_W+b])
            w_nxt[w*DATA_W+b] = hw_wr_data[w*DATA_W+b];
          else if (SELFCLR_MASK[w*DATA_W+b] && r_sc_pend[w*DATA_W+b])
            w_nxt[w*DATA_W+b] = 1'b0;
          w_sc_nxt[w*DATA_W+b] = SELFCLR_MASK[w*DATA_W+b] & w_wsel[w] & wr_be[b/8] & wr_data[b];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q       <= RESET_VAL;
      r_sc_pend <= '0;
      r_rd      <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_strobe  <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_q       <= w_nxt;
      r_sc_pend <= w_sc_nxt;
      r_ack     <= host_req;
      r_err     <= host_req & ~w_valid;
      r_strobe  <= w_strobe;
      r_irq     <= |(r_q[IRQ_STAT_IDX*DATA_W +: DATA_W] & r_q[IRQ_EN_IDX*DATA_W +: DATA_W]);
      // Reads return the pre-update contents; writes leave rd_data alone.
      if (host_req) begin
        if (!w_valid)
          r_rd <= '0;
        else if (!host_we)
          r_rd <= r_q[w_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign reg_q          = r_q;
  assign rd_data        = r_rd;
  assign host_ack       = r_ack;
  assign host_err       = r_err;
  assign host_wr_strobe = r_strobe;
  assign irq            = r_irq;

endmodule

// File: tb/tb_sd_host_regfile.sv
// tb/tb_sd_host_regfile.sv - directed and random checks of sd_host_regfile
// Word-level mask reference model; every cycle compares all outputs.
module tb_sd_host_regfile;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NW = 16;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               host_req;
  logic               host_we;
  logic [AW-1:0]      addrs;
  logic [DW-1:0]      wr_data;
  logic [DW/8-1:0]    wr_be;
  logic [DW-1:0]      rd_data;
  logic               host_ack;
  logic               host_err;
  logic [NW*DW-1:0]   hw_wr_data;
  logic [NW*DW-1:0]   hw_wr_en;
  logic [NW*DW-1:0]   reg_q;
  logic [NW-1:0]      host_wr_strobe;
  logic               irq;

  sd_host_regfile dut (
    .CLK(CLK), .RESET(RESET), .host_req(host_req), .host_we(host_we),
    .addrs(addrs), .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data),
    .host_ack(host_ack), .host_err(host_err), .hw_wr_data(hw_wr_data),
    .hw_wr_en(hw_wr_en), .reg_q(reg_q), .host_wr_strobe(host_wr_strobe), .irq(irq)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] m_reg  [NW];
  logic [DW-1:0] m_pend [NW];
  logic [DW-1:0] m_rd;
  logic          m_ack, m_err, m_irq;
  logic [NW-1:0] m_strobe;
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] ro_m(input int w);
    return (w == 9) ? 32'hFFFF_FFFF : 32'h0;
  endfunction
  function automatic logic [DW-1:0] w1c_m(input int w);
    return (w == 12) ? 32'h0000_FFFF : 32'h0;
  endfunction
  function automatic logic [DW-1:0] sc_m(input int w);
    return (w == 3) ? 32'h0000_8000 : 32'h0;
  endfunction

  function automatic logic [NW*DW-1:0] m_pack();
    logic [NW*DW-1:0] v;
    for (int w = 0; w < NW; w++) v[w*DW +: DW] = m_reg[w];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [NW*DW-1:0] obs, input logic [NW*DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("reg_q", reg_q, m_pack());
    chk("host_ack", {511'b0, host_ack}, {511'b0, m_ack});
    chk("host_err", {511'b0, host_err}, {511'b0, m_err});
    chk("rd_data", {480'b0, rd_data}, {480'b0, m_rd});
    chk("host_wr_strobe", {496'b0, host_wr_strobe}, {496'b0, m_strobe});
    chk("irq", {511'b0, irq}, {511'b0, m_irq});
  endtask

  task automatic do_reset(input logic req);
    RESET = 1'b1; host_req = req; host_we = 1'b1; addrs = '0;
    wr_data = 32'hFFFF_FFFF; wr_be = 4'hF; hw_wr_data = '1; hw_wr_en = '1;
    @(posedge CLK); #1;
    for (int w = 0; w < NW; w++) begin m_reg[w] = '0; m_pend[w] = '0; end
    m_rd = '0; m_ack = 0; m_err = 0; m_irq = 0; m_strobe = '0;
    RESET = 1'b0; host_req = 1'b0; hw_wr_en = '0;
    chk_all();
  endtask

  task automatic step(input logic req, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be,
                      input logic [NW*DW-1:0] hd, input logic [NW*DW-1:0] he);
    int idx;
    logic ok;
    logic [DW-1:0] bm, hm, en, hv, set, nw [NW], np [NW];
    host_req = req; host_we = we; addrs = a; wr_data = d; wr_be = be;
    hw_wr_data = hd; hw_wr_en = he;
    idx = int'(a[AW-1:2]);
    ok  = idx < NW;
    bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    m_irq = |(m_reg[12] & m_reg[13]);
    m_ack = req;
    m_err = req && !ok;
    m_strobe = '0;
    if (req && !ok) m_rd = '0;
    else if (req && !we) m_rd = m_reg[idx];
    if (req && we && ok && be != 0) m_strobe[idx] = 1'b1;
    for (int w = 0; w < NW; w++) begin
      hm  = (req && we && ok && idx == w) ? bm : '0;
      en  = he[w*DW +: DW];
      hv  = hd[w*DW +: DW];
      set = en & hv;
      nw[w] = (ro_m(w) & (set | (~en & m_reg[w])))
            | (w1c_m(w) & (set | (~en & m_reg[w] & ~(hm & d))))
            | (~ro_m(w) & ~w1c_m(w) &
               ((hm & d) | (~hm & set) | (~hm & ~en & m_reg[w] & ~m_pend[w])));
      np[w] = hm & d & sc_m(w);
    end
    for (int w = 0; w < NW; w++) begin m_reg[w] = nw[w]; m_pend[w] = np[w]; end
    @(posedge CLK); #1;
    chk_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 4'h0, '0, '0);
  endtask

  initial begin
    logic [NW*DW-1:0] hd, he;
    RESET = 1'b1; host_req = 0; host_we = 0; addrs = '0; wr_data = '0; wr_be = '0;
    hw_wr_data = '0; hw_wr_en = '0;
    do_reset(1'b0);
    do_reset(1'b1);
    chk("reset_ack", {511'b0, host_ack}, 512'b0);

    step(1, 1, 13'h000, 32'hDEADBEEF, 4'hF, '0, '0);
    chk("strobe0", {496'b0, host_wr_strobe}, 512'h1);
    step(1, 0, 13'h000, '0, 4'h0, '0, '0);
    chk("rd_deadbeef", {480'b0, rd_data}, {480'b0, 32'hDEADBEEF});

    step(1, 1, 13'h000, 32'h12345678, 4'h2, '0, '0);
    chk("be_word0", {480'b0, reg_q[31:0]}, {480'b0, 32'hDEAD56EF});
    step(1, 1, 13'h024, 32'hFFFFFFFF, 4'hF, '0, '0);
    chk("ro_word9", {480'b0, reg_q[9*DW +: DW]}, 512'b0);

    hd = '0; he = '0; hd[12*DW +: DW] = 32'h3; he[12*DW +: DW] = 32'h3;
    step(0, 0, '0, '0, 4'h0, hd, he);
    step(1, 1, 13'h030, 32'h1, 4'hF, '0, '0);
    chk("w1c_clear", {480'b0, reg_q[12*DW +: DW]}, {480'b0, 32'h2});
    hd = '0; he = '0; hd[12*DW+1] = 1'b1; he[12*DW+1] = 1'b1;
    step(1, 1, 13'h030, 32'h2, 4'hF, hd, he);
    chk("w1c_set_wins", {480'b0, reg_q[12*DW +: DW]}, {480'b0, 32'h2});

    step(1, 1, 13'h00C, 32'h8000, 4'hF, '0, '0);
    chk("sc_high", {511'b0, reg_q[3*DW+15]}, 512'h1);
    idle();
    chk("sc_low", {511'b0, reg_q[3*DW+15]}, 512'h0);
    idle();
    step(1, 1, 13'h00C, 32'h8000, 4'hF, '0, '0);
    step(1, 1, 13'h00C, 32'h8000, 4'hF, '0, '0);
    idle(); idle();

    step(1, 1, 13'h034, 32'h1, 4'hF, '0, '0);
    hd = '0; he = '0; hd[12*DW] = 1'b1; he[12*DW] = 1'b1;
    step(0, 0, '0, '0, 4'h0, hd, he);
    chk("irq_lag", {511'b0, irq}, 512'h0);
    idle();
    chk("irq_rise", {511'b0, irq}, 512'h1);
    step(1, 1, 13'h030, 32'h1, 4'hF, '0, '0);
    idle();
    chk("irq_fall", {511'b0, irq}, 512'h0);

    step(1, 0, 13'h040, '0, 4'h0, '0, '0);
    chk("oor_err", {511'b0, host_err}, 512'h1);
    step(1, 1, 13'h1FFC, 32'hFFFFFFFF, 4'hF, '0, '0);
    do_reset(1'b1);

    for (int i = 0; i < 400; i++) begin
      hd = '0; he = '0;
      for (int w = 0; w < NW; w++) begin
        hd[w*DW +: DW] = $urandom;
        if ($urandom_range(0, 3) == 0) he[w*DW +: DW] = $urandom & $urandom;
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           13'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
           $urandom, 4'($urandom_range(0, 15)), hd, he);
      if (i == 200) do_reset(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_host_regfile.md
Name: sd_host_regfile

Overview:
Parametrised, address-mapped register bank for the SD host controller. It replaces the hard-wired per-register instances and the separate start-detect logic.
- Host side: decodes the 13-bit host address bus behind a req/ack handshake with byte enables.
- Internal side: CMD, DAT and ADMA update registers through per-bit write enables.
- Per-bit attributes (read-only, write-1-to-clear, self-clearing), per-word host-write strobes and a masked interrupt output are added.

Parameters:
ADDR_W, 13, host byte-address width
DATA_W, 32, register width; multiple of 8
NUM_WORDS, 16, number of registers; word i sits at byte offset 4*i
RESET_VAL, all 0, NUM_WORDS*DATA_W reset image; word i occupies bits [i*DATA_W +: DATA_W]
RO_MASK, word 9 all ones, host-read-only bits (present-state word)
W1C_MASK, word 12 bits[15:0], write-1-to-clear bits (interrupt status)
SELFCLR_MASK, word 3 bit 15, host-written bits that auto-clear one cycle later (command start)
IRQ_STAT_IDX, 12, status word index used for irq
IRQ_EN_IDX, 13, enable word index used for irq

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
host_req  in  1  host access request, sampled each CLK
host_we  in  1  1 = write, 0 = read
addrs  in  ADDR_W  host byte address
wr_data  in  DATA_W  host write data
wr_be  in  DATA_W/8  host byte enables
rd_data  out  DATA_W  read data, valid with host_ack
host_ack  out  1  one-cycle access completion pulse
host_err  out  1  out-of-range access flag, valid with host_ack
hw_wr_data  in  NUM_WORDS*DATA_W  internal update data
hw_wr_en  in  NUM_WORDS*DATA_W  internal per-bit update enables
reg_q  out  NUM_WORDS*DATA_W  current contents of all registers
host_wr_strobe  out  NUM_WORDS  per-word pulse after a host write
irq  out  1  registered interrupt request

Behaviour:
Reset and addressing
- RESET is synchronous and active-high, with one clock, CLK. RESET beats every other input.
- On RESET: reg_q = RESET_VAL; rd_data = 0; host_ack = 0; host_err = 0; host_wr_strobe = 0; irq = 0. A host_req in the reset cycle is dropped, with no ack.
- Word index idx = addrs[ADDR_W-1:2]; addrs[1:0] are ignored. The access is valid iff idx < NUM_WORDS.

Host handshake
- Every cycle with host_req = 1 is accepted. host_ack pulses exactly one cycle later, giving a throughput of one access per cycle and no stalls.
- Reads: rd_data = contents of word idx at the sampling edge, before any same-cycle update. rd_data holds its value until the next ack.
- Invalid access: host_err = 1 with the ack, rd_data = 0, no register changes and no strobe.

Per-bit next value (for bits inside enabled bytes of a valid host write to word idx)
- RO bits: the host write has no effect.
- W1C bits: wr_data = 1 clears the bit. If hw_wr_en = 1 and hw_wr_data = 1 in the same cycle, the set wins. Otherwise hw_wr_en loads hw_wr_data.
- RW and SELFCLR bits: the host write wins over hw_wr_en. Otherwise hw_wr_en loads hw_wr_data.
- SELFCLR bits: a host-written 1 is visible on reg_q for exactly one cycle, then returns to 0. Auto-clear has lowest priority: a new host write or a hw set in the clear cycle takes effect instead.
- Bits with no host write and no hw enable hold their value.

Timing
- reg_q changes on the edge that samples the write, so the new value is visible in the same cycle as host_ack.
- host_wr_strobe[idx] pulses together with host_ack for a valid write with wr_be != 0. One write produces at most one strobe bit.
- irq <= |(word[IRQ_STAT_IDX] & word[IRQ_EN_IDX]), registered: one cycle behind reg_q.

Test Plan:
1. Reset → reg_q all 0, host_ack = 0, irq = 0. Write 0xDEADBEEF to 0x000 with be = 0xF; read 0x000 → ack one cycle later, rd_data = 0xDEADBEEF, host_wr_strobe[0] pulses.
2. Byte enables: word 0 holds 0xDEADBEEF, write 0x12345678 with be = 0x2 → word 0 = 0xDEAD56EF. Write 0xFFFFFFFF to 0x024 (RO) → word 9 unchanged, strobe[9] still pulses.
3. W1C: hw sets word 12 bits[1:0] (0x0003), host writes 0x0001 to 0x030 → word 12 = 0x0002. Same-cycle hw set of bit 1 with host clear of bit 1 → bit 1 stays 1.
4. Self-clear: write 0x8000 to 0x00C → bit 15 = 1 for exactly one cycle, then 0. Back-to-back writes hold it at 1 for two cycles.
5. irq: word 13 = 0x0001, then hw sets word 12 bit 0 → irq rises one cycle after reg_q. W1C clear of that bit → irq falls one cycle later.
6. Out of range: read 0x040 (idx 16) → host_err = 1, rd_data = 0, no strobe. Assert RESET during a host_req → no ack, all outputs return to reset values.
